// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and pointer type for the FIFO controller slice.
package fifo_ctrl_pkg;
    localparam int unsigned DEF_ADDR_SIZE = 4;
    localparam int unsigned DEF_DATA_SIZE = 8;
    localparam int unsigned DEF_DEPTH     = 16;

    typedef logic [DEF_ADDR_SIZE:0] ptr_t;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment enable and asynchronous reset.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_ADDR_SIZE + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with 1-cycle registered read.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic                 ram_re,
    output logic                 ram_oe,
    output logic [ADDR_SIZE-1:0] ram_wr_address,
    output logic [ADDR_SIZE-1:0] ram_rd_address,
    output logic [DATA_SIZE-1:0] ram_data_in,
    input  logic [DATA_SIZE-1:0] ram_data_out
);
    localparam logic [ADDR_SIZE:0] FULL_COUNT = DEPTH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] wr_ptr;
    logic [ADDR_SIZE:0] rd_ptr;
    logic               push_acc;
    logic               pop_acc;

    fifo_ptr #(.W(ADDR_SIZE + 1)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(ADDR_SIZE + 1)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    // Count equals DEPTH exactly when the pointers differ only in their MSB.
    always_comb begin
        count    = wr_ptr - rd_ptr;
        empty    = (wr_ptr == rd_ptr);
        full     = (count == FULL_COUNT);
        push_acc = push & ~full;
        pop_acc  = pop & ~empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pop_valid <= 1'b0;
        else
            pop_valid <= pop_acc;
    end

    always_comb begin
        ram_we         = push_acc;
        ram_re         = pop_acc | pop_valid;
        ram_oe         = pop_valid;
        ram_cs         = ram_we | ram_re;
        ram_wr_address = wr_ptr[ADDR_SIZE-1:0];
        ram_rd_address = rd_ptr[ADDR_SIZE-1:0];
        ram_data_in    = push_data;
        pop_data       = pop_valid ? ram_data_out : '0;
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full)
                overflow <= 1'b1;
            if (pop & empty)
                underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl wired to a behavioural dual-port RAM.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int unsigned AW = DEF_ADDR_SIZE;
    localparam int unsigned DW = DEF_DATA_SIZE;
    localparam int unsigned DEPTH = DEF_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid, full, empty, overflow, underflow;
    logic [AW:0]   count;
    logic          ram_cs, ram_we, ram_re, ram_oe;
    logic [AW-1:0] ram_wr_address, ram_rd_address;
    logic [DW-1:0] ram_data_in;
    wire  [DW-1:0] ram_data_out;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb [$];
    logic          exp_valid = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .pop_data       (pop_data),
        .pop_valid      (pop_valid),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_oe         (ram_oe),
        .ram_wr_address (ram_wr_address),
        .ram_rd_address (ram_rd_address),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out)
    );

    always @(posedge clk) begin
        if (ram_cs && ram_we)
            mem[ram_wr_address] <= ram_data_in;
        if (ram_cs && ram_re)
            ram_q <= mem[ram_rd_address];
    end
    assign ram_data_out = ram_oe ? ram_q : 'z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks it at the falling edge.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
        logic          pa, qa;
        logic [DW-1:0] e;
        int            sz;
        push = p; push_data = d; pop = q;
        @(negedge clk);
        sz = model_q.size();
        pa = p && (sz < int'(DEPTH));
        qa = q && (sz != 0);
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == int'(DEPTH)));
        check("empty", 32'(empty), 32'(sz == 0));
        check("ram_we", 32'(ram_we), 32'(pa));
        check("ram_re", 32'(ram_re), 32'(qa || exp_valid));
        check("ram_cs", 32'(ram_cs), 32'(pa || qa || exp_valid));
        check("pop_valid", 32'(pop_valid), 32'(exp_valid));
        if (exp_valid) begin
            e = sb.pop_front();
            check("pop_data", 32'(pop_data), 32'(e));
        end else begin
            check("pop_data_idle", 32'(pop_data), 32'h0);
        end
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
        @(posedge clk);
`ifdef FIFO_ERR_FLAGS_EN
        if (p && sz == int'(DEPTH)) exp_ovf = 1'b1;
        if (q && sz == 0) exp_unf = 1'b1;
`endif
        if (qa) sb.push_back(model_q.pop_front());
        if (pa) model_q.push_back(d);
        exp_valid = qa;
        #1;
    endtask

    task automatic drain();
        while (model_q.size() != 0) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_pop_valid", 32'(pop_valid), 32'h0);
        check("rst_ram_ctl", {28'h0, ram_cs, ram_we, ram_re, ram_oe}, 32'h0);
        check("rst_flags", {30'h0, overflow, underflow}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        step(1'b0, '0, 1'b0);

        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, '0, 1'b0);
        drain();

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 8'hBB, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();
        step(1'b1, 8'hCC, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        step(1'b0, '0, 1'b0);
        drain();

        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b0, '0, 1'b1);
        push = 1'b0; pop = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_pop_valid", 32'(pop_valid), 32'h0);
        check("rstmid_count", 32'(count), 32'h0);
        check("rstmid_empty", 32'(empty), 32'h1);
        model_q.delete(); sb.delete();
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
